// File: rtl/controlador_display_multiplexado_if.sv
// Display scan bus: frame load/enable from the value source, nibble/anode/frame-end back out.
interface controlador_display_multiplexado_if #(
   parameter int DIGITOS = 4
);
   logic                   Habilitar;
   logic                   Cargar;
   logic [4*DIGITOS-1:0]   Datos;
   logic [3:0]             Binario;
   logic [DIGITOS-1:0]     Anodos;
   logic                   FinCuadro;

   modport master (
      output Habilitar, Cargar, Datos,
      input  Binario, Anodos, FinCuadro
   );

   modport slave (
      input  Habilitar, Cargar, Datos,
      output Binario, Anodos, FinCuadro
   );
endinterface

// File: rtl/controlador_display_multiplexado.sv
// Multiplexed common-anode 7-segment scan controller with atomic frame reload and inter-digit blanking.
// Optional leading-zero blanking is enabled by defining SUPRESION_CEROS_EN.
module controlador_display_multiplexado #(
   parameter int DIGITOS = 4,
   parameter int DIVISOR = 50000,
   parameter int BLANCO  = 2
) (
   input  logic                             Reloj,
   input  logic                             Reset_n,
   controlador_display_multiplexado_if.slave bus
);

   localparam int MAXC = (DIVISOR > BLANCO) ? DIVISOR : BLANCO;
   localparam int CW   = $clog2(MAXC);
   localparam int IW   = $clog2(DIGITOS);
   localparam logic [CW-1:0] FIN_BLANCO  = CW'(BLANCO - 1);
   localparam logic [CW-1:0] FIN_MOSTRAR = CW'(DIVISOR - 1);
   localparam logic [IW-1:0] ULTIMO      = IW'(DIGITOS - 1);

   typedef enum logic [1:0] {ST_REPOSO, ST_BLANCO, ST_MOSTRAR} estado_t;

   estado_t                estado, estado_sig;
   logic [CW-1:0]          cuenta, cuenta_sig;
   logic [IW-1:0]          indice, indice_sig;
   logic [4*DIGITOS-1:0]   sombra, sombra_sig;
   logic [4*DIGITOS-1:0]   pendiente, pendiente_sig;
   logic                   hay_pendiente, hay_pendiente_sig;
   logic [3:0]             binario, binario_sig;
   logic [DIGITOS-1:0]     anodos, anodos_sig;
   logic                   fin_cuadro, fin_cuadro_sig;
   logic [DIGITOS-1:0]     visibles;

   function automatic logic [3:0] nibble(input logic [4*DIGITOS-1:0] marco,
                                         input logic [IW-1:0]        idx);
      return marco[4*idx +: 4];
   endfunction

   // Digit i is visible unless it and every more significant nibble are zero.
   always_comb begin
      visibles = '1;
`ifdef SUPRESION_CEROS_EN
      for (int i = 1; i < DIGITOS; i++) begin
         visibles[i] = (sombra >> (4*i)) != '0;
      end
`endif
   end

   always_comb begin
      estado_sig        = estado;
      cuenta_sig        = cuenta;
      indice_sig        = indice;
      sombra_sig        = sombra;
      pendiente_sig     = pendiente;
      hay_pendiente_sig = hay_pendiente;
      binario_sig       = binario;
      anodos_sig        = anodos;
      fin_cuadro_sig    = 1'b0;

      if (bus.Cargar) begin
         pendiente_sig     = bus.Datos;
         hay_pendiente_sig = 1'b1;
      end

      if (!bus.Habilitar) begin
         estado_sig = ST_REPOSO;
         cuenta_sig = '0;
         indice_sig = '0;
         anodos_sig = '1;
      end else begin
         case (estado)
            ST_REPOSO: begin
               estado_sig  = ST_BLANCO;
               cuenta_sig  = '0;
               indice_sig  = '0;
               binario_sig = sombra[3:0];
               anodos_sig  = '1;
            end
            ST_BLANCO: begin
               anodos_sig = '1;
               if (cuenta == FIN_BLANCO) begin
                  estado_sig = ST_MOSTRAR;
                  cuenta_sig = '0;
                  anodos_sig = ~(DIGITOS'(1) << indice) | ~visibles;
               end else begin
                  cuenta_sig = cuenta + 1'b1;
               end
            end
            ST_MOSTRAR: begin
               if (cuenta == FIN_MOSTRAR) begin
                  estado_sig = ST_BLANCO;
                  cuenta_sig = '0;
                  anodos_sig = '1;
                  if (indice == ULTIMO) begin
                     // Frame boundary: a strobe on this very cycle beats the pending frame.
                     indice_sig     = '0;
                     fin_cuadro_sig = 1'b1;
                     if (bus.Cargar) begin
                        sombra_sig        = bus.Datos;
                        hay_pendiente_sig = 1'b0;
                     end else if (hay_pendiente) begin
                        sombra_sig        = pendiente;
                        hay_pendiente_sig = 1'b0;
                     end
                     binario_sig = sombra_sig[3:0];
                  end else begin
                     indice_sig  = indice + 1'b1;
                     binario_sig = nibble(sombra, indice + 1'b1);
                  end
               end else begin
                  cuenta_sig = cuenta + 1'b1;
               end
            end
            default: begin
               estado_sig = ST_REPOSO;
               anodos_sig = '1;
            end
         endcase
      end
   end

   always_ff @(posedge Reloj or negedge Reset_n) begin
      if (!Reset_n) begin
         estado        <= ST_REPOSO;
         cuenta        <= '0;
         indice        <= '0;
         sombra        <= '0;
         pendiente     <= '0;
         hay_pendiente <= 1'b0;
         binario       <= '0;
         anodos        <= '1;
         fin_cuadro    <= 1'b0;
      end else begin
         estado        <= estado_sig;
         cuenta        <= cuenta_sig;
         indice        <= indice_sig;
         sombra        <= sombra_sig;
         pendiente     <= pendiente_sig;
         hay_pendiente <= hay_pendiente_sig;
         binario       <= binario_sig;
         anodos        <= anodos_sig;
         fin_cuadro    <= fin_cuadro_sig;
      end
   end

   assign bus.Binario   = binario;
   assign bus.Anodos    = anodos;
   assign bus.FinCuadro = fin_cuadro;

endmodule

// File: tb/tb_controlador_display_multiplexado.sv
// Directed bench for the multiplexed display controller with DIGITOS=4, DIVISOR=4, BLANCO=2 (24-cycle frame).
module tb_controlador_display_multiplexado;

   logic clk;
   logic rst_n;
   int   n_comp;
   int   n_err;

   controlador_display_multiplexado_if #(.DIGITOS(4)) bus ();

   controlador_display_multiplexado #(
      .DIGITOS(4),
      .DIVISOR(4),
      .BLANCO (2)
   ) dut (
      .Reloj  (clk),
      .Reset_n(rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_comp++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
      end
   endtask

   // Walks n cycles of a frame showing 'marco', checking every output; strobes Cargar at cycles ca/cb.
   task automatic escanear(input string tag, input logic [15:0] marco, input bit pulso,
                           input int n, input int ca, input logic [15:0] da,
                           input int cb, input logic [15:0] db);
      logic [3:0] uno;
      logic [3:0] esp_an;
      logic [3:0] esp_bin;
      int d;
      int ph;
      uno = 4'b0001;
      for (int c = 0; c < n; c++) begin
         d  = c / 6;
         ph = c % 6;
         esp_bin = marco[4*d +: 4];
         esp_an  = (ph < 2) ? 4'hF : ~(uno << d);
`ifdef SUPRESION_CEROS_EN
         if (d > 0 && (marco >> (4*d)) == 16'h0) esp_an = 4'hF;
`endif
         comprobar($sformatf("%s c%0d anodos", tag, c), {28'h0, bus.Anodos}, {28'h0, esp_an});
         comprobar($sformatf("%s c%0d binario", tag, c), {28'h0, bus.Binario}, {28'h0, esp_bin});
         comprobar($sformatf("%s c%0d fin", tag, c), {31'h0, bus.FinCuadro},
                   {31'h0, (c == 0 && pulso)});
         if (c == cb) begin
            bus.Cargar = 1'b1;
            bus.Datos  = db;
         end else if (c == ca) begin
            bus.Cargar = 1'b1;
            bus.Datos  = da;
         end else begin
            bus.Cargar = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.Cargar = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_comp        = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.Habilitar = 1'b0;
      bus.Cargar    = 1'b0;
      bus.Datos     = 16'h0;

      #12;
      comprobar("reset anodos", {28'h0, bus.Anodos}, 32'hF);
      comprobar("reset binario", {28'h0, bus.Binario}, 32'h0);
      comprobar("reset fin", {31'h0, bus.FinCuadro}, 32'h0);
      comprobar("reset hay_pendiente", {31'h0, dut.hay_pendiente}, 32'h0);

      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      comprobar("reposo anodos", {28'h0, bus.Anodos}, 32'hF);

      // Frame loaded while idle waits for the first boundary after enable.
      bus.Cargar = 1'b1;
      bus.Datos  = 16'h1A3F;
      @(posedge clk); #1;
      bus.Cargar = 1'b0;
      comprobar("carga en reposo hay_pendiente", {31'h0, dut.hay_pendiente}, 32'h1);
      bus.Habilitar = 1'b1;
      @(posedge clk); #1;

      escanear("f0", 16'h0000, 1'b0, 24, -1, 16'h0, -1, 16'h0);
      escanear("f1", 16'h1A3F, 1'b1, 24, 9, 16'h2222, -1, 16'h0);
      escanear("f2", 16'h2222, 1'b1, 24, 9, 16'h2222, 23, 16'h5555);
      comprobar("colision hay_pendiente", {31'h0, dut.hay_pendiente}, 32'h0);
      escanear("f3", 16'h5555, 1'b1, 24, -1, 16'h0, -1, 16'h0);
      escanear("f4", 16'h5555, 1'b1, 15, -1, 16'h0, -1, 16'h0);

      // Digit-2 lit slot: drop enable.
      comprobar("digito2 anodos", {28'h0, bus.Anodos}, 32'hB);
      bus.Habilitar = 1'b0;
      @(posedge clk); #1;
      comprobar("deshabilitar anodos", {28'h0, bus.Anodos}, 32'hF);
      @(posedge clk); #1;
      comprobar("reposo2 anodos", {28'h0, bus.Anodos}, 32'hF);
      bus.Habilitar = 1'b1;
      @(posedge clk); #1;
      escanear("rehab", 16'h5555, 1'b0, 5, -1, 16'h0, -1, 16'h0);

      // Asynchronous reset in the middle of a lit slot.
      comprobar("pre-reset anodos", {28'h0, bus.Anodos}, 32'hE);
      #3 rst_n = 1'b0;
      #1;
      comprobar("reset async anodos", {28'h0, bus.Anodos}, 32'hF);
      comprobar("reset async binario", {28'h0, bus.Binario}, 32'h0);
      comprobar("reset async fin", {31'h0, bus.FinCuadro}, 32'h0);
      bus.Habilitar = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      bus.Cargar = 1'b1;
      bus.Datos  = 16'h0050;
      @(posedge clk); #1;
      bus.Cargar    = 1'b0;
      bus.Habilitar = 1'b1;
      @(posedge clk); #1;
      escanear("z0", 16'h0000, 1'b0, 24, -1, 16'h0, -1, 16'h0);
      escanear("z1", 16'h0050, 1'b1, 24, -1, 16'h0, -1, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
      $finish;
   end

endmodule
